// File: rtl/spi_host_ctrl.sv
// spi_host_ctrl: mode-0 SPI initiator running one 16-bit {addr[6:0], rw, data[7:0]} frame per request.
// Define SPI_ABORT_EN to add the 'abort' input that cancels an in-flight frame.
module spi_host_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int READ_GAP    = 2,
  parameter int TAIL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
`ifdef SPI_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       s_clk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, ADDR, GAP, WDATA, RDATA, TAIL, DESEL
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [4:0]       periods;
  logic [14:0]      tx_shift;
  logic [7:0]       rx_shift;
  logic             rw_q;
  logic             aborted;
  logic             tick;
  logic             phase_done;
  logic             abort_req;

`ifdef SPI_ABORT_EN
  assign abort_req = abort && (state != IDLE) && (state != DESEL);
`else
  assign abort_req = 1'b0;
`endif

  // A state ends on the rising-edge tick after its last falling edge, so the
  // low half of every final period is kept before the next state begins.
  always_comb begin
    tick       = (div_cnt == DIV_LAST);
    periods    = 5'd0;
    next_state = DESEL;
    case (state)
      ADDR, WDATA, RDATA: periods = 5'd8;
      GAP:                periods = 5'(READ_GAP);
      TAIL:               periods = 5'(TAIL_CYCLES);
      default:            periods = 5'd0;
    endcase
    phase_done = (bit_cnt == periods);
    case (state)
      SETUP:   next_state = ADDR;
      ADDR:    next_state = rw_q ? ((READ_GAP > 0) ? GAP : RDATA) : WDATA;
      GAP:     next_state = RDATA;
      WDATA:   next_state = (TAIL_CYCLES > 0) ? TAIL : DESEL;
      default: next_state = DESEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= 8'h00;
      s_clk    <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= 5'd0;
      tx_shift <= 15'h0000;
      rx_shift <= 8'h00;
      rw_q     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_req) begin
        state   <= DESEL;
        s_clk   <= 1'b0;
        cs      <= 1'b1;
        mosi    <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= 5'd0;
        aborted <= 1'b1;
      end else if (state == IDLE) begin
        // A start seen while done is still high belongs to the finished frame.
        if (start && !done) begin
          state    <= SETUP;
          busy     <= 1'b1;
          cs       <= 1'b0;
          mosi     <= addr[6];
          tx_shift <= {addr[5:0], rw, wdata};
          rw_q     <= rw;
          div_cnt  <= '0;
          bit_cnt  <= 5'd0;
          aborted  <= 1'b0;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          if (state == DESEL) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (rw_q && !aborted) rdata <= rx_shift;
          end else if (s_clk) begin
            s_clk   <= 1'b0;
            bit_cnt <= bit_cnt + 5'd1;
            case (state)
              ADDR: begin
                tx_shift <= {tx_shift[13:0], 1'b0};
                mosi     <= (rw_q && bit_cnt == 5'd7) ? 1'b0 : tx_shift[14];
              end
              WDATA: begin
                tx_shift <= {tx_shift[13:0], 1'b0};
                mosi     <= tx_shift[14];
              end
              default: mosi <= 1'b0;
            endcase
          end else if (phase_done) begin
            state   <= next_state;
            bit_cnt <= 5'd0;
            if (next_state == DESEL) cs <= 1'b1;
            else s_clk <= 1'b1;
            if (next_state == RDATA) rx_shift <= {rx_shift[6:0], miso};
          end else begin
            s_clk <= 1'b1;
            if (state == RDATA) rx_shift <= {rx_shift[6:0], miso};
          end
        end
      end
    end
  end

endmodule
